// File: rtl/inst_decoder_if.sv
// Instruction-fetch and execution handshake between the instruction FIFO, the
// decoder and the PE-array controller.
interface inst_decoder_if #(
  parameter int INST_LEN = 128
);
  logic [INST_LEN-1:0] instruct;
  logic                inst_empty;
  logic                inst_req;
  logic                exec_start;
  logic                exec_done;

  modport master (
    input  instruct,
    input  inst_empty,
    input  exec_done,
    output inst_req,
    output exec_start
  );

  modport slave (
    output instruct,
    output inst_empty,
    output exec_done,
    input  inst_req,
    input  exec_start
  );
endinterface

// File: rtl/inst_decoder.sv
// Pops instruction words from the instruction FIFO, decodes them into registered
// ILC/BSR/PEC/W2C control fields and hands each one to the PE-array controller.
module inst_decoder #(
  parameter int X_MAC      = 4,
  parameter int ADDR_LEN_D = 9,
  parameter int ADDR_LEN_W = 9,
  parameter int INST_LEN   = 128,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  inst_decoder_if.master              bus,
  input  logic                        run_en_i,
  output logic                        busy_o,
  output logic [ADDR_LEN_D*X_MAC-1:0] ilc_st_addr_o,
  output logic                        ilc_ispad_o,
  output logic [8:0]                  ilc_linelen_o,
  output logic [3:0]                  bsr_iszero_o,
  output logic [7:0]                  bsr_buffermux_o,
  output logic                        pec_fromfifo_o,
  output logic                        pec_tofifo_o,
  output logic                        is_w2c_back_o,
  output logic [ADDR_LEN_D*X_MAC-1:0] w2c_st_addr_o,
  output logic [8:0]                  w2c_linelen_o,
  output logic                        w2c_pooled_o,
  output logic                        pooled_type_o,
  output logic [ADDR_LEN_W-1:0]       wb_st_rd_addr_o,
  output logic [3:0]                  w2c_shift_len_o,
  output logic [1:0]                  w2c_valid_mac_o,
  output logic [CNT_W-1:0]            inst_cnt_o,
  output logic [CNT_W-1:0]            skip_cnt_o,
  output logic                        rsv_err_o
);

  localparam int ST_W      = ADDR_LEN_D * X_MAC;
  localparam int ISPAD     = ST_W;
  localparam int LEN_LSB   = ST_W + 1;
  localparam int IZ_LSB    = LEN_LSB + 9;
  localparam int BM_LSB    = IZ_LSB + 4;
  localparam int FROMF     = BM_LSB + 8;
  localparam int TOF       = FROMF + 1;
  localparam int W2CB      = TOF + 1;
  localparam int W2ST_LSB  = W2CB + 1;
  localparam int W2LEN_LSB = W2ST_LSB + ST_W;
  localparam int W2POOL    = W2LEN_LSB + 9;
  localparam int PTYPE     = W2POOL + 1;
  localparam int WB_LSB    = PTYPE + 1;
  localparam int SHL_LSB   = WB_LSB + ADDR_LEN_W;
  localparam int VMAC_LSB  = SHL_LSB + 4;
  localparam int FLD_W     = VMAC_LSB + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_EXEC
  } state_t;

  state_t             state_q;
  logic               inst_req_q;
  logic               exec_start_q;
  logic               busy_q;
  logic               rsv_err_q;
  logic [FLD_W-1:0]   fld_q;
  logic [CNT_W-1:0]   inst_cnt_q;
  logic [CNT_W-1:0]   skip_cnt_q;

  // The word is read in LATCH: the FIFO presents the popped word after the pop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      inst_req_q   <= 1'b0;
      exec_start_q <= 1'b0;
      busy_q       <= 1'b0;
      rsv_err_q    <= 1'b0;
      fld_q        <= '0;
      inst_cnt_q   <= '0;
      skip_cnt_q   <= '0;
    end else begin
      inst_req_q   <= 1'b0;
      exec_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_en_i && !bus.inst_empty) begin
            state_q    <= S_FETCH;
            inst_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          fld_q <= bus.instruct[FLD_W-1:0];
          if (|bus.instruct[INST_LEN-1:FLD_W]) rsv_err_q <= 1'b1;
          if (bus.instruct[LEN_LSB+8:LEN_LSB] == 9'd0) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            skip_cnt_q <= skip_cnt_q + 1'b1;
          end else begin
            state_q      <= S_ISSUE;
            exec_start_q <= 1'b1;
            inst_cnt_q   <= inst_cnt_q + 1'b1;
          end
        end
        S_ISSUE: state_q <= S_EXEC;
        S_EXEC: begin
          if (bus.exec_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst_req   = inst_req_q;
  assign bus.exec_start = exec_start_q;
  assign busy_o         = busy_q;
  assign rsv_err_o      = rsv_err_q;
  assign inst_cnt_o     = inst_cnt_q;
  assign skip_cnt_o     = skip_cnt_q;

  assign ilc_st_addr_o   = fld_q[ST_W-1:0];
  assign ilc_ispad_o     = fld_q[ISPAD];
  assign ilc_linelen_o   = fld_q[LEN_LSB+8:LEN_LSB];
  assign bsr_iszero_o    = fld_q[IZ_LSB+3:IZ_LSB];
  assign bsr_buffermux_o = fld_q[BM_LSB+7:BM_LSB];
  assign pec_fromfifo_o  = fld_q[FROMF];
  assign pec_tofifo_o    = fld_q[TOF];
  assign is_w2c_back_o   = fld_q[W2CB];
  assign w2c_st_addr_o   = fld_q[W2ST_LSB+ST_W-1:W2ST_LSB];
  assign w2c_linelen_o   = fld_q[W2LEN_LSB+8:W2LEN_LSB];
  assign w2c_pooled_o    = fld_q[W2POOL];
  assign pooled_type_o   = fld_q[PTYPE];
  assign wb_st_rd_addr_o = fld_q[WB_LSB+ADDR_LEN_W-1:WB_LSB];
  assign w2c_shift_len_o = fld_q[SHL_LSB+3:SHL_LSB];
  assign w2c_valid_mac_o = fld_q[VMAC_LSB+1:VMAC_LSB];

endmodule

// File: tb/tb_inst_decoder.sv
// Directed bench for inst_decoder: FIFO model on the pop side, hand-built words
// with known field values, and a narrow counter width so wrap-around is reachable.
module tb_inst_decoder;

  logic        clk;
  logic        rst_n;
  logic        run_en;
  logic        busy;
  logic [35:0] ilc_st_addr;
  logic        ilc_ispad;
  logic [8:0]  ilc_linelen;
  logic [3:0]  bsr_iszero;
  logic [7:0]  bsr_buffermux;
  logic        pec_fromfifo;
  logic        pec_tofifo;
  logic        is_w2c_back;
  logic [35:0] w2c_st_addr;
  logic [8:0]  w2c_linelen;
  logic        w2c_pooled;
  logic        pooled_type;
  logic [8:0]  wb_st_rd_addr;
  logic [3:0]  w2c_shift_len;
  logic [1:0]  w2c_valid_mac;
  logic [3:0]  inst_cnt;
  logic [3:0]  skip_cnt;
  logic        rsv_err;

  int n_cmp = 0;
  int n_bad = 0;
  int pops  = 0;
  logic [127:0] fifo[$];

  inst_decoder_if #(.INST_LEN(128)) bus ();

  inst_decoder #(
    .X_MAC(4), .ADDR_LEN_D(9), .ADDR_LEN_W(9), .INST_LEN(128), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .run_en_i(run_en), .busy_o(busy),
    .ilc_st_addr_o(ilc_st_addr), .ilc_ispad_o(ilc_ispad), .ilc_linelen_o(ilc_linelen),
    .bsr_iszero_o(bsr_iszero), .bsr_buffermux_o(bsr_buffermux),
    .pec_fromfifo_o(pec_fromfifo), .pec_tofifo_o(pec_tofifo), .is_w2c_back_o(is_w2c_back),
    .w2c_st_addr_o(w2c_st_addr), .w2c_linelen_o(w2c_linelen), .w2c_pooled_o(w2c_pooled),
    .pooled_type_o(pooled_type), .wb_st_rd_addr_o(wb_st_rd_addr),
    .w2c_shift_len_o(w2c_shift_len), .w2c_valid_mac_o(w2c_valid_mac),
    .inst_cnt_o(inst_cnt), .skip_cnt_o(skip_cnt), .rsv_err_o(rsv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read FIFO: the popped word appears on instruct after the pop edge.
  always @(posedge clk) begin
    if (bus.inst_req) begin
      if (fifo.size() > 0) bus.instruct = fifo.pop_front();
      pops++;
      bus.inst_empty = (fifo.size() == 0);
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] w);
    fifo.push_back(w);
    bus.inst_empty = 1'b0;
  endtask

  task automatic pulse_done();
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
  endtask

  function automatic logic [127:0] mk(
    input logic [35:0] st, input logic ispad, input logic [8:0] len, input logic [3:0] iz,
    input logic [7:0] bm, input logic ff, input logic tf, input logic wb,
    input logic [35:0] w2st, input logic [8:0] w2len, input logic w2pool, input logic ptype,
    input logic [8:0] wbaddr, input logic [3:0] shl, input logic [1:0] vmac, input logic [4:0] rsv);
    return {rsv, vmac, shl, wbaddr, ptype, w2pool, w2len, w2st, wb, tf, ff, bm, iz, len, ispad, st};
  endfunction

  logic [127:0] w1, w2, w3, w4, w5;
  logic busy_all, busy_any, req_seen;
  int lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    w1 = mk(36'h1_2345_6789, 1'b1, 9'd64, 4'h3, 8'hE4, 1'b1, 1'b0, 1'b1,
            36'hA_BCDE_F012, 9'h0AA, 1'b0, 1'b1, 9'h123, 4'h7, 2'h1, 5'h00);
    w2 = mk(36'h0, 1'b0, 9'd0, 4'hA, 8'h11, 1'b0, 1'b0, 1'b0,
            36'h0, 9'h000, 1'b0, 1'b0, 9'h000, 4'h0, 2'h0, 5'h00);
    w3 = mk(36'h0, 1'b0, 9'd5, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0,
            36'h9_8765_4321, 9'h005, 1'b1, 1'b0, 9'h000, 4'h0, 2'h0, 5'h10);
    w4 = mk(36'hF_0F0F_0F0F, 1'b0, 9'h1FF, 4'h5, 8'h3C, 1'b1, 1'b1, 1'b0,
            36'h0_0000_0001, 9'h100, 1'b0, 1'b1, 9'h155, 4'h9, 2'h2, 5'h00);
    w5 = mk(36'h0, 1'b0, 9'd7, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0,
            36'h0, 9'h000, 1'b0, 1'b0, 9'h000, 4'h0, 2'h0, 5'h00);

    rst_n = 1'b0; run_en = 1'b1; bus.exec_done = 1'b0;
    bus.inst_empty = 1'b1; bus.instruct = '0;
    #12;
    check_val("rst_req", bus.inst_req, 0);
    check_val("rst_start", bus.exec_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_cnts", {inst_cnt, skip_cnt, rsv_err, ilc_linelen}, 0);

    // Basic issue latency and field decode
    push(w1);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check_val("t1_req_c1", bus.inst_req, 1);
    check_val("t1_busy_c1", busy, 1);
    tick();
    check_val("t1_req_c2", bus.inst_req, 0);
    check_val("t1_start_c2", bus.exec_start, 0);
    tick();
    check_val("t1_start_c3", bus.exec_start, 1);
    check_val("t1_linelen", ilc_linelen, 9'd64);
    check_val("t1_bmux", bsr_buffermux, 8'hE4);
    check_val("t1_inst_cnt", inst_cnt, 1);
    check_val("t1_fields_a", {ilc_st_addr, ilc_ispad, bsr_iszero, pec_fromfifo, pec_tofifo, is_w2c_back},
              {36'h1_2345_6789, 1'b1, 4'h3, 1'b1, 1'b0, 1'b1});
    check_val("t1_fields_b", {w2c_st_addr, w2c_linelen, w2c_pooled, pooled_type, wb_st_rd_addr, w2c_shift_len, w2c_valid_mac},
              {36'hA_BCDE_F012, 9'h0AA, 1'b0, 1'b1, 9'h123, 4'h7, 2'h1});
    tick();
    check_val("t1_start_c4", bus.exec_start, 0);

    // Stall in EXEC, then resume two cycles after done
    push(w2);
    busy_all = 1'b1; req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_all &= busy;
      req_seen |= bus.inst_req;
    end
    check_val("t2_busy_hold", busy_all, 1);
    check_val("t2_no_req", req_seen, 0);
    check_val("t2_pops", pops, 1);
    pulse_done();
    check_val("t2_idle_busy", busy, 0);
    check_val("t2_idle_req", bus.inst_req, 0);
    tick();
    check_val("t2_req_after", bus.inst_req, 1);

    // Zero line length: skipped, no start
    tick();
    check_val("t3_start_latch", bus.exec_start, 0);
    tick();
    check_val("t3_start", bus.exec_start, 0);
    check_val("t3_skip_cnt", skip_cnt, 1);
    check_val("t3_inst_cnt", inst_cnt, 1);
    check_val("t3_busy", busy, 0);
    check_val("t3_iszero", bsr_iszero, 4'hA);
    tick();
    check_val("t3_empty_idle", bus.inst_req, 0);

    // Reserved bit set: flagged but still issued; flag is sticky
    push(w3);
    tick();
    check_val("t4_fetch", bus.inst_req, 1);
    tick(); tick();
    check_val("t4_start", bus.exec_start, 1);
    check_val("t4_rsv_err", rsv_err, 1);
    check_val("t4_inst_cnt", inst_cnt, 2);
    check_val("t4_w2c_st", w2c_st_addr, 36'h9_8765_4321);
    check_val("t4_w2c_pool", {w2c_pooled, pec_tofifo}, 2'b11);
    tick();
    pulse_done();
    push(w4);
    tick(); tick(); tick();
    check_val("t4b_start", bus.exec_start, 1);
    check_val("t4b_rsv_sticky", rsv_err, 1);
    check_val("t4b_inst_cnt", inst_cnt, 3);
    check_val("t4b_fields", {ilc_linelen, wb_st_rd_addr, w2c_shift_len, w2c_valid_mac, pooled_type, w2c_linelen},
              {9'h1FF, 9'h155, 4'h9, 2'h2, 1'b1, 9'h100});
    tick();

    // run_en dropped during EXEC: finish then stay idle
    push(w5);
    run_en = 1'b0;
    tick(); tick();
    pulse_done();
    req_seen = 1'b0; busy_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      req_seen |= bus.inst_req;
      busy_any |= busy;
    end
    check_val("t5_no_req", req_seen, 0);
    check_val("t5_idle", busy_any, 0);
    check_val("t5_pops", pops, 4);
    check_val("t5_fields_held", {ilc_linelen, bsr_buffermux, ilc_st_addr}, {9'h1FF, 8'h3C, 36'hF_0F0F_0F0F});

    // Async reset in the middle of EXEC
    run_en = 1'b1;
    tick();
    check_val("t6_fetch", bus.inst_req, 1);
    tick(); tick();
    check_val("t6_start", bus.exec_start, 1);
    check_val("t6_inst_cnt", inst_cnt, 4);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_req_start", {bus.inst_req, bus.exec_start}, 0);
    check_val("t6_rst_regs", {inst_cnt, skip_cnt, rsv_err, ilc_linelen, w2c_st_addr}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Counter wrap (4-bit counter): 15 issues reach all-ones, the 16th wraps to 0
    for (int k = 1; k <= 16; k++) begin
      push(mk(36'h0, 1'b0, 9'(k), 4'h0, 8'h00, 1'b0, 1'b0, 1'b0,
              36'h0, 9'h000, 1'b0, 1'b0, 9'h000, 4'h0, 2'h0, 5'h00));
      lat = 0;
      while (!bus.exec_start && lat < 12) begin
        tick();
        lat++;
      end
      if (k == 1) check_val("wrap_latency", lat, 3);
      if (k == 15) check_val("wrap_cnt_max", inst_cnt, 4'hF);
      if (k == 16) begin
        check_val("wrap_start", bus.exec_start, 1);
        check_val("wrap_cnt_zero", inst_cnt, 0);
        check_val("wrap_linelen", ilc_linelen, 9'd16);
      end
      tick();
      pulse_done();
    end
    check_val("wrap_rsv_clear", rsv_err, 0);
    check_val("wrap_skip", skip_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
